// File: rtl/seg_pkg.sv
// Shared constants, segment encodings and converter state type for the
// taxi-meter display back end.
package seg_pkg;

  localparam int unsigned DIGITS = 6;
  localparam int unsigned BIN_W  = 20;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned SEG_W  = 8;
  localparam int unsigned IDX_W  = $clog2(DIGITS);

  localparam logic [BIN_W-1:0] PRICE_MAX = BIN_W'(999_999);

  // Active-low segment patterns: bit 7 = dp, bits 6..0 = g..a
  localparam logic [SEG_W-1:0] SEG_D0    = 8'hC0;
  localparam logic [SEG_W-1:0] SEG_D1    = 8'hF9;
  localparam logic [SEG_W-1:0] SEG_D2    = 8'hA4;
  localparam logic [SEG_W-1:0] SEG_D3    = 8'hB0;
  localparam logic [SEG_W-1:0] SEG_D4    = 8'h99;
  localparam logic [SEG_W-1:0] SEG_D5    = 8'h92;
  localparam logic [SEG_W-1:0] SEG_D6    = 8'h82;
  localparam logic [SEG_W-1:0] SEG_D7    = 8'hF8;
  localparam logic [SEG_W-1:0] SEG_D8    = 8'h80;
  localparam logic [SEG_W-1:0] SEG_D9    = 8'h90;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
  localparam logic [SEG_W-1:0] SEG_MINUS = 8'hBF;

  typedef enum logic [1:0] {
    CONV_IDLE = 2'd0,
    CONV_RUN  = 2'd1,
    CONV_LOAD = 2'd2
  } conv_state_e;

  function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] digit);
    logic [SEG_W-1:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_D0;
      4'd1:    pattern = SEG_D1;
      4'd2:    pattern = SEG_D2;
      4'd3:    pattern = SEG_D3;
      4'd4:    pattern = SEG_D4;
      4'd5:    pattern = SEG_D5;
      4'd6:    pattern = SEG_D6;
      4'd7:    pattern = SEG_D7;
      4'd8:    pattern = SEG_D8;
      4'd9:    pattern = SEG_D9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one start pulse, 20 shift iterations,
// then a one-cycle done with the six-digit BCD result.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int unsigned SR_W   = BCD_W + BIN_W;
  localparam int unsigned ITER_W = $clog2(BIN_W + 1);

  conv_state_e      state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [BCD_W-1:0] adj_c;

  // Add-3 correction on every BCD nibble that would overflow after the shift
  always_comb begin
    adj_c = sr_q[SR_W-1 -: BCD_W];
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CONV_IDLE;
      sr_q    <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    iter_d  = iter_q;
    case (state_q)
      CONV_IDLE: begin
        if (start) begin
          sr_d    = {BCD_W'(0), bin};
          iter_d  = '0;
          state_d = CONV_RUN;
        end
      end
      CONV_RUN: begin
        sr_d   = SR_W'({adj_c, sr_q[BIN_W-1:0]} << 1);
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(BIN_W - 1)) begin
          state_d = CONV_LOAD;
        end
      end
      CONV_LOAD: begin
        state_d = CONV_IDLE;
      end
      default: begin
        state_d = CONV_IDLE;
      end
    endcase
  end

  assign busy = (state_q != CONV_IDLE);
  assign done = (state_q == CONV_LOAD);
  assign bcd  = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/seg_scan_driver.sv
// Taxi-meter display back end: price -> BCD conversion and 6-digit scan.
// Leading-zero blanking and minus sign are enabled with macro SEG_LZB_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned CNT_MAX = 49_999
)
(
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [BIN_W-1:0]  price,
  input  logic [DIGITS-1:0] point,
  input  logic              sign,
  input  logic              seg_en,
  output logic [DIGITS-1:0] sel,
  output logic [SEG_W-1:0]  seg
);

  localparam int unsigned CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  logic [BIN_W-1:0]  price_clamped_c;
  logic              start_c;
  logic              conv_busy;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;

  logic [BIN_W-1:0]  last_val_q, last_val_d;
  logic [BCD_W-1:0]  digit_q, digit_d;
  logic [DIGITS-1:0] point_q, point_d;
  logic              sign_q, sign_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [SEG_W-1:0]  seg_q, seg_d;

  logic [DIGITS-1:0] blank_c;
  logic [DIGITS-1:0] minus_c;
  logic [SEG_W-1:0]  cur_seg_c;

  assign price_clamped_c = (price > PRICE_MAX) ? PRICE_MAX : price;
  assign start_c         = !conv_busy && (price_clamped_c != last_val_q);

  bin2bcd_seq u_bin2bcd (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .start (start_c),
    .bin   (price_clamped_c),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

`ifdef SEG_LZB_EN
  // A digit is blank when it and every digit above it is zero with no dp set
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank_c    = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (digit_q[4*i +: 4] == 4'd0) && !point_q[i];
      blank_c[i] = zero_above;
    end
  end

  always_comb begin
    minus_c = '0;
    for (int i = 1; i < DIGITS; i++) begin
      minus_c[i] = sign_q && blank_c[i] && !blank_c[i-1];
    end
  end
`else
  logic sign_unused;
  assign sign_unused = sign_q;
  assign blank_c     = '0;
  assign minus_c     = '0;
`endif

  // Segment pattern for the digit currently being scanned
  always_comb begin
    logic [3:0] nib;
    logic       is_blank;
    logic       is_minus;
    logic       has_dp;
    nib      = '0;
    is_blank = 1'b0;
    is_minus = 1'b0;
    has_dp   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib      = digit_q[4*i +: 4];
        is_blank = blank_c[i];
        is_minus = minus_c[i];
        has_dp   = point_q[i];
      end
    end
    if (is_minus) begin
      cur_seg_c = SEG_MINUS;
    end else if (is_blank) begin
      cur_seg_c = SEG_BLANK;
    end else begin
      cur_seg_c = seg_encode(nib);
    end
    if (has_dp) begin
      cur_seg_c[SEG_W-1] = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      last_val_q <= '0;
      digit_q    <= '0;
      point_q    <= '0;
      sign_q     <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      sel_q      <= '1;
      seg_q      <= SEG_BLANK;
    end else begin
      last_val_q <= last_val_d;
      digit_q    <= digit_d;
      point_q    <= point_d;
      sign_q     <= sign_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  always_comb begin
    last_val_d = last_val_q;
    digit_d    = digit_q;
    point_d    = point_q;
    sign_d     = sign_q;
    cnt_d      = cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    sel_d      = '1;
    seg_d      = SEG_BLANK;

    if (start_c) begin
      last_val_d = price_clamped_c;
    end

    // Decorations are captured alongside the digits they belong to
    if (conv_done) begin
      digit_d = conv_bcd;
      point_d = point;
      sign_d  = sign;
    end

    if (cnt_q == CNT_W'(CNT_MAX)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    if (seg_en) begin
      sel_d = ~(DIGITS'(1) << idx_q);
      seg_d = cur_seg_c;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule
